// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter for a single-port memory.
// Writes complete in the grant cycle. Reads hold the bus until the data returns READ_LAT cycles later.
module mem_bus_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        arb_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } state_t;

  localparam logic [1:0] LAT_M1 = 2'(READ_LAT - 1);

  state_t      state, state_nx;
  logic [1:0]  cnt, cnt_nx;
  logic        last, last_nx;
  logic        owner, owner_nx;

  logic              grant;
  logic              grant_out;
  logic              sel;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              rd_done;

  // Requester selection; on a tie the one not granted last wins
  always_comb begin
    grant = 1'b0;
    sel   = 1'b0;
    if (state == IDLE && (m0_req || m1_req)) begin
      grant = 1'b1;
      sel   = (m0_req && m1_req) ? ~last : m1_req;
    end
  end

  assign sel_we    = sel ? m1_we    : m0_we;
  assign sel_addr  = sel ? m1_addr  : m0_addr;
  assign sel_wdata = sel ? m1_wdata : m0_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
      last  <= 1'b1;
      owner <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      last  <= last_nx;
      owner <= owner_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    last_nx  = last;
    owner_nx = owner;
    case (state)
      IDLE: begin
        if (grant) begin
          last_nx = sel;
          if (!sel_we) begin
            owner_nx = sel;
            cnt_nx   = LAT_M1;
            state_nx = (READ_LAT == 1) ? RD_DONE : RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        // Leave as the counter reaches zero so rvalid lands READ_LAT cycles after gnt
        cnt_nx = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
        if (cnt <= 2'd1) state_nx = RD_DONE;
      end
      RD_DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 2'd0;
      end
    endcase
  end

  // Outputs are forced quiet while reset is held, even with requests pending
  always_comb begin
    grant_out = grant & rst;
    rd_done   = (state == RD_DONE);
    m0_gnt    = grant_out & ~sel;
    m1_gnt    = grant_out & sel;
    mem_en    = grant_out;
    mem_we    = grant_out & sel_we;
    mem_addr  = grant_out ? sel_addr  : '0;
    mem_wdata = grant_out ? sel_wdata : '0;
    m0_rvalid = rd_done & ~owner;
    m1_rvalid = rd_done & owner;
    m0_rdata  = m0_rvalid ? mem_rdata : '0;
    m1_rdata  = m1_rvalid ? mem_rdata : '0;
    arb_state = state;
  end

endmodule
